// File: rtl/router_pkg.sv
// Shared types and default sizing for the router output-port arbiter.
package router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int NUM_REQ   = 8;
  localparam int DATA_W    = 32;
  localparam int PKT_WORDS = 4;
  localparam int TIMEOUT   = 32;

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// Round-robin priority pick: first set req bit at or after rr_ptr, searching cyclically.
module rr_pick #(
  parameter int NUM_REQ = router_pkg::NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         rr_ptr,
  output logic               any,
  output logic [2:0]         idx
);

  always_comb begin : pick
    int j;
    any = |req;
    idx = '0;
    // Walk from the lowest priority offset down so the closest match to rr_ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) idx = 3'(j);
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port arbiter: round-robin packet grant, one-cycle registered forwarding.
// Optional stall watchdog enabled by defining ROUTER_ARB_WATCHDOG_EN.
module router_out_arbiter #(
  parameter int NUM_REQ   = router_pkg::NUM_REQ,
  parameter int DATA_W    = router_pkg::DATA_W,
  parameter int PKT_WORDS = router_pkg::PKT_WORDS,
  parameter int TIMEOUT   = router_pkg::TIMEOUT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] fifo_data,
  output logic [NUM_REQ-1:0]        read_en,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      abort
);
  import router_pkg::*;

  localparam int CNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  state_e             state_q;
  logic [2:0]         rr_ptr_q;
  logic [2:0]         grant_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;

  logic               pick_any;
  logic [2:0]         pick_idx;
  logic [2:0]         rr_ptr_d;
  logic [DATA_W-1:0]  sel_data;
  logic               rd;
  logic               last_word;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // Reads are gated by reset so a mid-packet reset stops the FIFO strobe immediately.
  assign rd        = (state_q == XFER) && req[grant_q] && out_ready && !reset;
  assign last_word = (word_cnt_q == CNT_W'(PKT_WORDS - 1));
  assign rr_ptr_d  = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
  assign sel_data  = fifo_data[int'(grant_q)*DATA_W +: DATA_W];

  always_comb begin
    read_en          = '0;
    read_en[grant_q] = rd;
  end

`ifdef ROUTER_ARB_WATCHDOG_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt_q;
  logic               abort_q;
  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      word_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef ROUTER_ARB_WATCHDOG_EN
      stall_cnt_q <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      out_valid_q <= rd;
      if (rd) out_data_q <= sel_data;
`ifdef ROUTER_ARB_WATCHDOG_EN
      abort_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_idx;
            word_cnt_q <= '0;
            state_q    <= XFER;
`ifdef ROUTER_ARB_WATCHDOG_EN
            stall_cnt_q <= '0;
`endif
          end
        end
        XFER: begin
          if (rd) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (last_word) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_ptr_d;
            end
`ifdef ROUTER_ARB_WATCHDOG_EN
            stall_cnt_q <= '0;
          end else if (!req[grant_q]) begin
            // Owner went empty: give up after TIMEOUT stall cycles as if the packet had ended.
            if (stall_cnt_q == STALL_W'(TIMEOUT - 1)) begin
              state_q     <= IDLE;
              rr_ptr_q    <= rr_ptr_d;
              stall_cnt_q <= '0;
              abort_q     <= 1'b1;
            end else begin
              stall_cnt_q <= stall_cnt_q + 1'b1;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_router_out_arbiter.sv
// Scoreboard bench for router_out_arbiter (default build, 8 requesters, 4-word packets).
module tb_router_out_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   req;
  logic [255:0] fifo_data;
  logic [7:0]   read_en;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic [2:0]   grant_id;
  logic         busy;
  logic         abort;

  router_out_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .fifo_data (fifo_data),
    .read_en   (read_en),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .grant_id  (grant_id),
    .busy      (busy),
    .abort     (abort)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] seq [8];
  logic [31:0] exp_q [$];
  logic [2:0]  glog [$];
  logic        prev_busy;
  int          vcount;

  // Reference model of the arbiter
  bit          m_state;
  logic [2:0]  m_grant;
  logic [2:0]  m_rr;
  int          m_cnt;

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < 8; i++) fifo_data[i*32 +: 32] = {8'(i), seq[i]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic rd);
    int j;
    if (!m_state) begin
      for (int k = 7; k >= 0; k--) begin
        j = (int'(m_rr) + k) % 8;
        if (req[j]) begin
          m_grant = 3'(j);
          m_state = 1'b1;
        end
      end
      m_cnt = 0;
    end else if (rd) begin
      if (m_cnt == 3) begin
        m_state = 1'b0;
        m_rr    = 3'((int'(m_grant) + 1) % 8);
      end
      m_cnt++;
    end
  endtask

  task automatic step();
    logic       exp_rd;
    logic [7:0] exp_re;
    logic [7:0] got_re;
    #1;
    exp_rd = m_state && req[m_grant] && out_ready;
    exp_re = '0;
    if (exp_rd) exp_re[m_grant] = 1'b1;
    chk("read_en", 32'(read_en), 32'(exp_re));
    if (exp_rd) exp_q.push_back({5'd0, m_grant, seq[m_grant]});
    got_re = read_en;
    model_update(exp_rd);
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) if (got_re[i]) seq[i] = seq[i] + 24'd1;
    chk("out_valid", 32'(out_valid), 32'(exp_rd));
    if (out_valid) begin
      vcount++;
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else chk("out_data", out_data, exp_q.pop_front());
    end
    chk("busy", 32'(busy), 32'(m_state));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
    chk("abort", 32'(abort), 32'd0);
    if (busy && !prev_busy) glog.push_back(grant_id);
    prev_busy = busy;
    @(negedge clock);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_read_en", 32'(read_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    repeat (2) @(negedge clock);
    reset     = 1'b0;
    m_state   = 1'b0;
    m_grant   = '0;
    m_rr      = '0;
    m_cnt     = 0;
    prev_busy = 1'b0;
    exp_q.delete();
    glog.delete();
  endtask

  task automatic chk_glog(input string tag, input logic [2:0] g0, input logic [2:0] g1,
                          input logic [2:0] g2, input int n);
    logic [2:0] want [3];
    want[0] = g0; want[1] = g1; want[2] = g2;
    chk({tag, "_n"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < n && i < glog.size(); i++) chk(tag, 32'(glog[i]), 32'(want[i]));
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) seq[i] = 24'(i * 16);
    @(negedge clock);
    do_reset();

    // Single requester, then rr_ptr must have moved past it
    req = 8'b0000_0100; out_ready = 1'b1;
    steps(5);
    req = 8'h00;
    steps(2);
    req = 8'hFF;
    steps(5);
    req = 8'h00;
    steps(2);
    chk_glog("grant_seq_a", 3'd2, 3'd3, 3'd0, 2);

    // All requesting for three packets from reset
    do_reset();
    req = 8'hFF;
    steps(15);
    req = 8'h00;
    steps(2);
    chk_glog("grant_seq_b", 3'd0, 3'd1, 3'd2, 3);

    // Wrap from 7 back to 0
    do_reset();
    req = 8'b0100_0000;
    steps(5);
    req = 8'b1000_0001;
    steps(10);
    req = 8'h00;
    steps(2);
    chk_glog("grant_seq_c", 3'd6, 3'd7, 3'd0, 3);

    // Backpressure mid-packet, late request and owner going empty must not break the packet
    do_reset();
    vcount = 0;
    req = 8'b0000_0010;
    steps(3);
    out_ready = 1'b0;
    req = 8'b0000_0011;
    steps(5);
    out_ready = 1'b1;
    req = 8'b0000_0001;
    steps(3);
    req = 8'b0000_0011;
    steps(2);
    req = 8'h00;
    steps(2);
    chk("words_per_pkt", 32'(vcount), 32'd4);
    chk_glog("grant_seq_d", 3'd1, 3'd0, 3'd0, 1);

    // Reset after the second word of a packet
    do_reset();
    req = 8'b0000_1000;
    steps(3);
    do_reset();
    req = 8'h00;
    steps(2);
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/router_out_arbiter.md
ROUTER_OUT_ARBITER -- requirements
Module: router_out_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 8, sets the number of input FIFOs competing for this output port.
REQ-002 Parameter DATA_W, default 32, sets the word width.
REQ-003 Parameter PKT_WORDS, default 4, sets the words per packet; the grant is held for one full packet.
REQ-004 Parameter TIMEOUT, default 32, sets the stall cycles before watchdog abort.
REQ-005 Port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port req, input, NUM_REQ bits: FIFO i is non-empty and its head word targets this port.
REQ-008 Port fifo_data, input, NUM_REQ*DATA_W bits: FIFO i data_out occupies slice i.
REQ-009 Port read_en, output, NUM_REQ bits: read strobe to FIFO i.
REQ-010 Port out_ready, input, 1 bit: downstream can accept a word this cycle.
REQ-011 Port out_data, output, DATA_W bits: forwarded word.
REQ-012 Port out_valid, output, 1 bit: out_data is valid.
REQ-013 Port grant_id, output, 3 bits: index of the current owner.
REQ-014 Port busy, output, 1 bit: a packet is in progress.
REQ-015 Port abort, output, 1 bit: one-cycle pulse on watchdog release.

Function
REQ-016 The FSM SHALL have exactly the states IDLE and XFER.
REQ-017 In IDLE with req nonzero, the block SHALL pick the first set req bit at or after rr_ptr (cyclic), load grant_id, clear word_cnt and enter XFER on the next edge.
REQ-018 In IDLE with req zero, the block SHALL hold state and keep read_en at 0.
REQ-019 In XFER, read_en[grant_id] SHALL be combinationally equal to req[grant_id] AND out_ready; every other read_en bit SHALL be 0, so at most one bit is ever set.
REQ-020 On each cycle with read_en active, out_data SHALL register fifo_data[grant_id] and out_valid SHALL be 1 on the next cycle; otherwise out_valid SHALL be 0 (latency: 1 cycle).
REQ-021 word_cnt SHALL increment on each read; a read with word_cnt == PKT_WORDS-1 SHALL return the FSM to IDLE and set rr_ptr = (grant_id+1) mod NUM_REQ.
REQ-022 A new request arriving during XFER SHALL NOT preempt the current packet.
REQ-023 busy SHALL equal (state == XFER).
REQ-024 rr_ptr and grant_id SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-025 Reset SHALL force state=IDLE, rr_ptr=0, grant_id=0, word_cnt=0, stall_cnt=0, out_data=0, out_valid=0 and abort=0; read_en SHALL be 0 while reset is high.
REQ-026 Reset asserted mid-packet SHALL drop the packet immediately with no further reads.

Configuration
REQ-027 With macro ROUTER_ARB_WATCHDOG_EN defined, stall_cnt SHALL count XFER cycles where req[grant_id]=0 and clear on every read.
REQ-028 With the watchdog enabled, reaching TIMEOUT-1 SHALL return the FSM to IDLE, advance rr_ptr as in a normal completion and pulse abort for 1 cycle.
REQ-029 Without ROUTER_ARB_WATCHDOG_EN, the block SHALL wait indefinitely, abort SHALL be tied to 0 and no stall_cnt logic SHALL exist.

Structure
REQ-030 A shared package router_pkg SHALL hold the FSM state enum, NUM_REQ, DATA_W and the PKT_WORDS default.
REQ-031 The round-robin priority pick SHALL be a sub-module rr_pick (inputs req and rr_ptr; outputs any and idx).

Verification
REQ-032 Scenario: req=8'b0000_0100, out_ready=1 -> grant_id=2; read_en[2] high for 4 cycles; out_valid high for 4 cycles lagging by 1; busy falls; rr_ptr=3.
REQ-033 Scenario: req=8'hFF held for 3 packets from reset -> grants in order 0, 1, 2; each packet is 4 words.
REQ-034 Scenario: req=8'b1000_0001 with rr_ptr=7 -> grant 7, then 0 (wrap).
REQ-035 Scenario: out_ready low for 5 cycles mid-packet -> read_en=0 and out_valid=0 during the stall; the packet still completes with exactly 4 words.
REQ-036 Scenario: reset asserted after the 2nd word -> read_en=0 that cycle; state=IDLE; outputs at reset values.
REQ-037 Scenario (watchdog enabled): req[grant_id] drops after 1 word -> abort pulses once after 32 stall cycles; the next requester is granted.
